// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (TXD/RXD/CON registers) with a level interrupt.
module uart_mmio #(
  parameter int          BAUD_DIV  = 5208,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int HALF = BAUD_DIV / 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;
  st_t tx_st, tx_st_n, rx_st, rx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n, rx_sync;
  logic [7:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n, txd, rxd;
  logic [1:0] en;
  logic tx_done, rx_ready, frame_err, overrun, tx_busy, tx_line, tx_fin, rx_ok, rx_bad;
  logic sel_txd, sel_rxd, sel_con, tx_start, rx_s, rx_fall, tx_last, rx_last;
  logic [6:0] con;
  logic unused;
  assign unused   = ^{wdata[31:8], addr[1:0]};
  assign sel_txd  = addr[31:2] == BASE_ADDR[31:2];
  assign sel_rxd  = addr[31:2] == BASE_ADDR[31:2] + 30'd1;
  assign sel_con  = addr[31:2] == BASE_ADDR[31:2] + 30'd2;
  assign tx_busy  = tx_st != IDLE;
  assign tx_start = wr & sel_txd & ~tx_busy;
  assign con      = {overrun, frame_err, tx_busy, rx_ready, tx_done, en};
  // rx_sync[1] is the synchronized line; rx_sync[2] is its previous value for edge detection
  assign rx_s     = rx_sync[1];
  assign rx_fall  = rx_sync[2] & ~rx_sync[1];
  assign tx_last  = tx_cnt == CW'(BAUD_DIV - 1);
  assign rx_last  = rx_cnt == CW'(BAUD_DIV - 1);
  always_comb begin
    rdata = !rd ? 32'h0 : sel_txd ? {24'h0, txd} : sel_rxd ? {24'h0, rxd} : sel_con ? {25'h0, con} : 32'h0;
  end
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_last ? '0 : tx_cnt + CW'(1);
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_fin   = 1'b0;
    case (tx_st)
      IDLE: begin
        tx_cnt_n = '0;
        if (tx_start) begin
          tx_st_n = START;
          tx_sh_n = wdata[7:0];
        end
      end
      START: if (tx_last) begin
        tx_st_n  = DATA;
        tx_bit_n = '0;
      end
      DATA: if (tx_last) begin
        tx_sh_n  = tx_sh >> 1;
        tx_bit_n = tx_bit + 3'd1;
        tx_st_n  = tx_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (tx_last) begin
        tx_st_n = IDLE;
        tx_fin  = 1'b1;
      end
    endcase
    // the line register follows the next state so each level lasts exactly BAUD_DIV cycles
    tx_line = tx_st_n == START ? 1'b0 : tx_st_n == DATA ? tx_sh_n[0] : 1'b1;
  end
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + CW'(1);
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_ok    = 1'b0;
    rx_bad   = 1'b0;
    case (rx_st)
      IDLE: begin
        rx_cnt_n = '0;
        rx_st_n  = rx_fall ? START : IDLE;
      end
      START: if (rx_cnt == CW'(HALF - 1)) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n  = rx_s ? IDLE : DATA;
      end
      DATA: if (rx_last) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        rx_st_n  = rx_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (rx_last) begin
        rx_cnt_n = '0;
        rx_st_n  = IDLE;
        rx_ok    = rx_s;
        rx_bad   = ~rx_s;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st     <= IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      uart_tx   <= 1'b1;
      rx_st     <= IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_sync   <= 3'b111;
      txd       <= '0;
      rxd       <= '0;
      en        <= '0;
      tx_done   <= 1'b0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      tx_st     <= tx_st_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_sh     <= tx_sh_n;
      uart_tx   <= tx_line;
      rx_st     <= rx_st_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_sh     <= rx_sh_n;
      rx_sync   <= {rx_sync[1:0], uart_rx};
      txd       <= tx_start ? wdata[7:0] : txd;
      rxd       <= rx_ok ? rx_sh : rxd;
      en        <= wr & sel_con ? wdata[1:0] : en;
      tx_done   <= tx_fin | (tx_done & ~(rd & sel_con));
      rx_ready  <= rx_ok | (rx_ready & ~(rd & sel_rxd));
      frame_err <= rx_bad | (frame_err & ~(rd & sel_con));
      overrun   <= (rx_ok & rx_ready) | (overrun & ~(rd & sel_con));
      irq       <= (en[0] & tx_done) | (en[1] & rx_ready);
    end
  end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral on the single-cycle CPU data bus, in parallel with the data RAM / peripheral decoder.
- Consumes the CPU's ALU-computed address, register-file store data and MemRd/MemWr strobes.
- Returns read data and an interrupt request into the CPU's write-back / IRQ path.
- Provides 8N1 transmit and receive with a fixed baud divisor.

Parameters:
- BAUD_DIV, 5208, clock cycles per bit (50 MHz / 9600 baud); must be >= 4
- BASE_ADDR, 32'h40000018, word address of UART_TXD; UART_RXD = BASE+4, UART_CON = BASE+8

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- addr  in  32  byte address from CPU ALU output
- wdata  in  32  store data (DataBusB)
- rd  in  1  read strobe (MemRd)
- wr  in  1  write strobe (MemWr)
- rdata  out  32  read data, combinational
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output, registered
- irq  out  1  interrupt request, level

Behaviour:
- Reset (synchronous): uart_tx=1, TX/RX FSMs in IDLE, all counters 0, UART_TXD/UART_RXD/UART_CON = 0, irq=0.
- Address decode: exact match on addr[31:2] only; non-matching access gives rdata=0 and no side effects.
- Reads: rdata is combinational and valid in the same cycle rd is high.
  - TXD read returns {24'b0, last written byte}.
  - RXD read returns {24'b0, rx byte}.
  - CON read returns {25'b0, con[6:0]}.
- Read side effects commit on the rising edge where rd is sampled high.
- UART_CON bits:
  - [0] tx_int_en (RW)
  - [1] rx_int_en (RW)
  - [2] tx_done (RO; set at end of stop bit; cleared by CON read)
  - [3] rx_ready (RO; set on a good frame; cleared by RXD read)
  - [4] tx_busy (RO)
  - [5] frame_err (RO sticky; cleared by CON read)
  - [6] overrun (RO sticky; cleared by CON read)
- CON write updates bits [1:0] only.
- irq = (con[0] & con[2]) | (con[1] & con[3]), registered; changes the cycle after the flag changes.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Write to TXD in IDLE latches wdata[7:0] and enters START next cycle; tx_busy=1 from that cycle.
  - Each state holds uart_tx for exactly BAUD_DIV cycles: START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
  - A full frame is 10*BAUD_DIV cycles.
  - On leaving STOP: tx_busy=0, tx_done=1.
  - Write to TXD while busy is ignored; TXD and the frame in progress are unchanged.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - uart_rx passes through a 2-flop synchronizer (2-cycle latency); the idle level is 1.
  - A synchronized 1->0 transition in IDLE enters START.
  - After BAUD_DIV/2 cycles the line is re-sampled; if it is 1, the event is a glitch and the FSM returns to IDLE with no flag change.
  - Otherwise 8 data samples are taken every BAUD_DIV cycles (mid-bit), LSB first, then the stop sample.
  - Stop=1: load UART_RXD. If rx_ready is already 1, also set overrun (new data overwrites). Then set rx_ready.
  - Stop=0: set frame_err, discard the byte, leave UART_RXD and rx_ready unchanged.
  - After the stop sample, return to IDLE immediately; a start edge during the remaining half stop bit is accepted.
- Simultaneous events: when a flag set and a clear-by-read happen in the same cycle, set wins (flag stays 1; rdata shows the pre-edge value).
- A CON write in the same cycle as a hardware flag update: [1:0] take wdata, status bits take the hardware update.
- TX and RX operate fully independently (loopback of uart_tx to uart_rx is legal).
- Reset mid-frame aborts both FSMs, forces uart_tx=1 immediately on that edge, and clears all flags.

Test Plan (BAUD_DIV=4):
- Reset then idle: uart_tx=1, irq=0, CON read = 0x00, RXD read = 0x00.
- Write 0x1A5 to BASE; sample uart_tx every 4 cycles -> 0,1,0,1,0,0,1,0,1,1 (byte 0xA5, LSB first); tx_busy=1 throughout; tx_done=1 after 40 cycles. With CON=0x1, irq rises one cycle later; a CON read returns 0x05 and irq falls the next cycle.
- TX busy: write 0x11 then 0x22 ten cycles later -> only the 0x11 frame is emitted; TXD reads 0x11.
- RX: drive 0x3C at 4 cycles/bit with CON=0x2 -> rx_ready=1, irq=1, RXD reads 0x3C; rx_ready and irq clear after the read.
- RX errors: 2-cycle low glitch -> no flag change; frame with stop=0 -> frame_err=1, RXD unchanged; two good bytes 0x01 then 0x02 without reading -> RXD=0x02, overrun=1.
- Loopback 0x7E with reset asserted at cycle 20 -> uart_tx=1 and all flags 0 after that edge; after reset release, a fresh 0x7E frame is received correctly.
